alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Single-requester sequencer that owns the shared 32-bit adder (full_adder_32) and iterative multiplier (multiplier_32) and executes UM arithmetic ops ADD, MUL, DIV and NAND.
- Takes one op at a time over a valid/ready request channel.
- Drives the shared datapath and sequences the multiplier load and wait.
- Runs an internal shift-subtract divider.
- Returns a 32-bit mod-2^32 result over a valid/ready response channel.

Parameters:
MUL_LAT, 34, cycles from the end of the mul_load pulse until mul_lo is valid
DIV_STEPS, 32, divider iterations (fixed at 32; any other value is unsupported)

Ports:
clk  in  1  clock; all state on posedge
reset  in  1  synchronous, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_op  in  2  0=ADD 1=MUL 2=DIV 3=NAND
req_a  in  32  operand A
req_b  in  32  operand B
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  result
rsp_err  out  1  divide-by-zero flag, qualified by rsp_valid
add_a  out  32  adder operand A
add_b  out  32  adder operand B
add_cin  out  1  adder carry-in
add_sum  in  32  adder sum
add_cout  in  1  adder carry-out (unused for ADD)
mul_a  out  32  multiplier operand A
mul_b  out  32  multiplier operand B
mul_load  out  1  one-cycle multiplier start pulse
mul_reset  out  1  active-high multiplier reset
mul_lo  in  32  product bits [31:0] (mout1)
mul_hi  in  32  product bits [63:32] (mout2), ignored

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; req_ready=0 during reset; rsp_valid=0; rsp_data=0; rsp_err=0; mul_load=0.
  - mul_reset = ~reset, registered, so it is high for the cycle following each reset edge.
  - Reset mid-operation aborts the op, drops any pending response and re-initialises the divider.
- States: IDLE, ADD, MUL_LD, MUL_WAIT, DIV, RESP.
- Accept:
  - req_ready=1 only in IDLE.
  - A request is accepted at posedge N when req_valid && req_ready; operands and op are latched.
- ADD:
  - add_a=A, add_b=B, add_cin=0 during the cycle after accept.
  - add_sum is captured at N+1; carry is discarded (wrap mod 2^32).
- NAND:
  - Result ~(A&B), registered at N+1. Uses no shared resource.
- MUL:
  - MUL_LD: mul_a/mul_b driven, mul_load=1 for exactly one cycle (N to N+1).
  - MUL_WAIT: counter runs from MUL_LAT down; mul_a/mul_b stay stable.
  - mul_lo is captured at edge N+1+MUL_LAT.
- DIV (unsigned restoring):
  - One quotient bit per cycle; subtraction is done through the shared adder (add_a=partial remainder, add_b=~divisor, add_cin=1).
  - No borrow (add_cout=1) means subtract and quotient bit=1.
  - Quotient is ready at edge N+DIV_STEPS+1.
  - If B==0: no iterations; rsp_err=1, rsp_data=0 at N+1.
- The adder is driven only in ADD and DIV. Otherwise add_a=add_b=0 and add_cin=0.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err stay stable until rsp_valid && rsp_ready at a posedge.
  - That posedge clears rsp_valid and moves to IDLE.
  - req_ready rises the following cycle (no same-cycle bypass).
- req_valid while busy is ignored (not dropped); the requester must hold it.
- rsp_err=0 for every op except DIV-by-zero.

Optional Feature:
UMIX_ALU_STATS_EN
- Defined: adds outputs stat_ops[31:0], the count of completed responses (handshakes), and stat_busy[31:0], cycles with state!=IDLE.
- Both counters wrap at 2^32 and clear on reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD 24,44 accepted at edge N, rsp_ready=1 -> rsp_valid at N+1, rsp_data=68, rsp_err=0. ADD 0xFFFFFFFF,1 -> 0x00000000.
- MUL 24,56 with MUL_LAT=34 -> mul_load high for exactly one cycle; rsp_data=1344 after edge N+35; req_ready=0 throughout.
- DIV 100,7 -> rsp_data=14 after edge N+33. DIV 0xFFFFFFFF,1 -> 0xFFFFFFFF. DIV 5,0 -> rsp_err=1, rsp_data=0 at N+1.
- NAND 0xF0F0F0F0,0xFF00FF00 -> 0x0FFF0FFF.
- Backpressure: rsp_ready=0 for 3 cycles after rsp_valid -> rsp_data held stable, req_ready=0; after the handshake, req_ready=1 next cycle and back-to-back ADD works.
- Reset: reset=0 during MUL_WAIT cycle 10 -> next cycle rsp_valid=0 and mul_reset=1; after release, the MUL 3,5 latency matches the normal MUL timing (rsp_valid after edge N+1+MUL_LAT) and rsp_data=15.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequencer for the shared 32-bit adder and multiplier: ADD, MUL, DIV, NAND.
// Optional UMIX_ALU_STATS_EN adds stat_ops/stat_busy counters.
module alu_sequencer #(
    parameter int MUL_LAT   = 34,
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_load,
    output logic        mul_reset,
    input  logic [31:0] mul_lo,
`ifdef UMIX_ALU_STATS_EN
    output logic [31:0] stat_ops,
    output logic [31:0] stat_busy,
`endif
    input  logic [31:0] mul_hi
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    localparam logic [7:0] MUL_N = 8'(MUL_LAT);
    localparam logic [7:0] DIV_N = 8'(DIV_STEPS);

    typedef enum logic [2:0] {
        IDLE, ADD, MUL_LD, MUL_WAIT, DIV, RESP
    } state_t;

    state_t      state, state_n;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [7:0]  cnt;
    logic [31:0] rem, quo;
    logic [31:0] rem_sh;
    logic        div_ok;
    logic        accept;
    logic        unused_ok;

    assign unused_ok = ^mul_hi;

    assign req_ready = (state == IDLE) && reset;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign mul_load  = (state == MUL_LD);

    // Shifted remainder can carry a 33rd bit; if set the subtract always fits.
    assign rem_sh = {rem[30:0], quo[31]};
    assign div_ok = add_cout | rem[31];

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        mul_reset <= ~reset;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (req_op)
                        OP_MUL:  state_n = MUL_LD;
                        OP_DIV:  state_n = (req_b == 32'd0) ? ADD : DIV;
                        OP_ADD:  state_n = ADD;
                        OP_NAND: state_n = ADD;
                    endcase
                end
            end
            ADD:      state_n = RESP;
            MUL_LD:   state_n = MUL_WAIT;
            MUL_WAIT: if (cnt == 8'd1) state_n = RESP;
            DIV:      if (cnt == DIV_N) state_n = RESP;
            RESP:     if (rsp_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_cin = 1'b0;
        mul_a   = 32'd0;
        mul_b   = 32'd0;
        unique case (state)
            ADD: begin
                if (op_q == OP_ADD) begin
                    add_a = a_q;
                    add_b = b_q;
                end
            end
            DIV: begin
                add_a   = rem_sh;
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
            MUL_LD, MUL_WAIT: begin
                mul_a = a_q;
                mul_b = b_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= OP_ADD;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            cnt      <= 8'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        rem  <= 32'd0;
                        quo  <= req_a;
                        cnt  <= 8'd0;
                    end
                end
                ADD: begin
                    rsp_err <= (op_q == OP_DIV);
                    unique case (op_q)
                        OP_ADD:  rsp_data <= add_sum;
                        OP_NAND: rsp_data <= ~(a_q & b_q);
                        default: rsp_data <= 32'd0;
                    endcase
                end
                MUL_LD: cnt <= MUL_N;
                MUL_WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        rsp_data <= mul_lo;
                        rsp_err  <= 1'b0;
                    end
                end
                DIV: begin
                    if (cnt == DIV_N) begin
                        rsp_data <= quo;
                        rsp_err  <= 1'b0;
                    end else begin
                        rem <= div_ok ? add_sum : rem_sh;
                        quo <= {quo[30:0], div_ok};
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: ;
                default: ;
            endcase
        end
    end

`ifdef UMIX_ALU_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_ops  <= 32'd0;
            stat_busy <= 32'd0;
        end else begin
            if (rsp_valid && rsp_ready) stat_ops <= stat_ops + 32'd1;
            if (state != IDLE) stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with behavioural adder and
// multiplier models attached to the shared-datapath ports.
module tb_alu_sequencer;

    localparam int MUL_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic [31:0] mul_a, mul_b, mul_lo, mul_hi;
    logic        mul_load, mul_reset;
`ifdef UMIX_ALU_STATS_EN
    logic [31:0] stat_ops, stat_busy;
`endif

    alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_STEPS(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load),
        .mul_reset(mul_reset), .mul_lo(mul_lo),
`ifdef UMIX_ALU_STATS_EN
        .stat_ops(stat_ops), .stat_busy(stat_busy),
`endif
        .mul_hi(mul_hi)
    );

    always #5 clk = ~clk;

    // adder model
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    // multiplier model: product valid MUL_LAT edges after the load edge
    logic [63:0] prod;
    int          mcnt;
    logic        mbusy;
    always @(posedge clk) begin
        if (mul_reset) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (mul_load) begin
            prod  <= {32'd0, mul_a} * {32'd0, mul_b};
            mcnt  <= MUL_LAT - 1;
            mbusy <= 1'b1;
        end else if (mbusy && mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mul_lo = (mbusy && mcnt == 0) ? prod[31:0] : 32'hDEADBEEF;
    assign mul_hi = (mbusy && mcnt == 0) ? prod[63:32] : 32'hDEADBEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // monitor
    logic seen = 1'b0;
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got=%h expected=none", rsp_data);
            end else begin
                if (!seen) begin
                    chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    seen = 1'b1;
                end
                chk("rsp_data", rsp_data, sb[0].data);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb[0].err});
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // called at a negedge; returns #1 after the accept edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d,
                         input logic e, input int lat, input bit push);
        exp_t x;
        int   n;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout got=0 expected=1");
            checks++;
            errors++;
        end
        x.data = d;
        x.err  = e;
        x.acc  = cyc + 1;
        x.lat  = lat;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rsp_timeout got=%0d expected=0 pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    int rdy_hi, add_hi, loads, n;

    always @(negedge clk) if (mul_load) loads++;

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;
        loads     = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mul_load", {31'd0, mul_load}, 32'd0);
        chk("rst_mul_reset", {31'd0, mul_reset}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        issue(2'd0, 32'd24, 32'd44, 32'd68, 1'b0, 1, 1);
        wait_done();
        issue(2'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1, 1);
        wait_done();
        issue(2'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1, 1);
        wait_done();

        // MUL: one load pulse, requester blocked, adder idle
        loads  = 0;
        rdy_hi = 0;
        add_hi = 0;
        issue(2'd1, 32'd24, 32'd56, 32'd1344, 1'b0, 35, 1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            if (req_ready) rdy_hi++;
            if (add_a != 0 || add_b != 0 || add_cin) add_hi++;
            n++;
        end
        wait_done();
        chk("mul_load_pulses", 32'(loads), 32'd1);
        chk("mul_req_ready_low", 32'(rdy_hi), 32'd0);
        chk("mul_adder_idle", 32'(add_hi), 32'd0);

        issue(2'd2, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1);
        wait_done();
        issue(2'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33, 1);
        wait_done();
        issue(2'd2, 32'hFFFFFFFF, 32'h80000001, 32'd1, 1'b0, 33, 1);
        wait_done();
        issue(2'd2, 32'd1000, 32'd1000, 32'd1, 1'b0, 33, 1);
        wait_done();
        issue(2'd2, 32'd5, 32'd0, 32'd0, 1'b1, 1, 1);
        wait_done();

        // backpressure
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        issue(2'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1, 1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) begin
            @(negedge clk);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after", {31'd0, req_ready}, 32'd1);
        chk("bp_valid_after", {31'd0, rsp_valid}, 32'd0);
        issue(2'd0, 32'd7, 32'd8, 32'd15, 1'b0, 1, 1);
        wait_done();

        // reset during MUL_WAIT
        issue(2'd1, 32'd3, 32'd5, 32'd15, 1'b0, 35, 0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_mul_reset", {31'd0, mul_reset}, 32'd1);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        issue(2'd1, 32'd3, 32'd5, 32'd15, 1'b0, 35, 1);
        wait_done();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
